// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shifter: FS codes, FSM states, widths.
// Optional build macro: SHIFT_BY4_EN (4-bit shift steps).
package shift_pkg;

  localparam int SH_W   = 32;
  localparam int SH_SHW = 5;

  localparam logic [4:0] FS_SLL = 5'h0C;
  localparam logic [4:0] FS_SRL = 5'h0D;
  localparam logic [4:0] FS_SRA = 5'h0E;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic fs_valid(input logic [4:0] fs);
    return (fs == FS_SLL) || (fs == FS_SRL) || (fs == FS_SRA);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves data by 1 (or 4) per call.
// Optional build macro: SHIFT_BY4_EN adds the by4 step input.
module shift_step
  import shift_pkg::*;
#(
  parameter int W = SH_W
) (
  input  logic [4:0]   op,
  input  logic [W-1:0] data,
`ifdef SHIFT_BY4_EN
  input  logic         by4,
`endif
  output logic [W-1:0] res
);

  always_comb begin
    res = data;
`ifdef SHIFT_BY4_EN
    if (by4) begin
      unique case (1'b1)
        op == FS_SLL: res = {data[W-5:0], 4'b0};
        op == FS_SRL: res = {4'b0, data[W-1:4]};
        op == FS_SRA: res = {{4{data[W-1]}}, data[W-1:4]};
        default:      res = data;
      endcase
    end else begin
`endif
      unique case (1'b1)
        op == FS_SLL: res = {data[W-2:0], 1'b0};
        op == FS_SRL: res = {1'b0, data[W-1:1]};
        op == FS_SRA: res = {data[W-1], data[W-1:1]};
        default:      res = data;
      endcase
`ifdef SHIFT_BY4_EN
    end
`endif
  end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle SLL/SRL/SRA unit with start/busy/done handshake.
// Optional build macro: SHIFT_BY4_EN (shift 4 bits per cycle while cnt>=4).
module iter_shift_unit
  import shift_pkg::*;
#(
  parameter int W   = SH_W,
  parameter int SHW = SH_SHW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [4:0]     FS,
  input  logic [W-1:0]   T,
  input  logic [SHW-1:0] shamt,
  output logic [W-1:0]   Y,
  output logic           busy,
  output logic           done
);

  state_t         state, state_nx;
  logic [W-1:0]   work, step_res;
  logic [SHW-1:0] cnt, cnt_step;
  logic [4:0]     op;
  logic           fs_ok, last;

  assign fs_ok = fs_valid(FS);

`ifdef SHIFT_BY4_EN
  logic by4;
  assign by4      = cnt >= SHW'(4);
  assign cnt_step = by4 ? SHW'(4) : SHW'(1);
`else
  assign cnt_step = SHW'(1);
`endif

  // final step is the one that brings cnt to exactly zero
  assign last = (cnt == cnt_step);

  shift_step #(.W(W)) u_step (
    .op   (op),
    .data (work),
`ifdef SHIFT_BY4_EN
    .by4  (by4),
`endif
    .res  (step_res)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:
        if (start)
          state_nx = (shamt != '0 && fs_ok) ? ST_SHIFT : ST_DONE;
      ST_SHIFT:
        if (last) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      work <= '0;
      cnt  <= '0;
      op   <= '0;
      Y    <= '0;
    end else begin
      unique case (state)
        ST_IDLE:
          if (start) begin
            work <= fs_ok ? T : '0;
            cnt  <= shamt;
            op   <= FS;
            if (shamt == '0 || !fs_ok)
              Y <= fs_ok ? T : '0;
          end
        ST_SHIFT: begin
          work <= step_res;
          cnt  <= cnt - cnt_step;
          if (last) Y <= step_res;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_iter_shift_unit.sv
// Self-checking bench for iter_shift_unit: cycle model plus directed vectors.
// Honours SHIFT_BY4_EN for expected latencies.
module tb_iter_shift_unit;
  import shift_pkg::*;

  logic        clk = 0;
  logic        reset = 0;
  logic        start = 0;
  logic [4:0]  FS = 0;
  logic [31:0] T = 0;
  logic [4:0]  shamt = 0;
  logic [31:0] Y;
  logic        busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  iter_shift_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .FS    (FS),
    .T     (T),
    .shamt (shamt),
    .Y     (Y),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [4:0] f,
                                          input logic [31:0] t,
                                          input logic [4:0] s);
    case (f)
      FS_SLL:  return t << s;
      FS_SRL:  return t >> s;
      FS_SRA:  return $signed(t) >>> s;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] f, input logic [4:0] s);
    int n;
    n = int'(s);
    if (!fs_valid(f) || n == 0) return 1;
`ifdef SHIFT_BY4_EN
    return n / 4 + n % 4 + 1;
`else
    return n + 1;
`endif
  endfunction

  // model: cycles left until idle, done on the last one
  int          m_left = 0;
  logic [31:0] m_y = 0, m_pend = 0;

  always @(posedge clk) begin
    if (!reset) begin
      m_left = 0;
      m_y    = 0;
    end else if (m_left != 0) begin
      m_left = m_left - 1;
    end else if (start) begin
      m_left = ref_lat(FS, shamt);
      m_pend = ref_res(FS, T, shamt);
    end
    if (reset && m_left == 1) m_y = m_pend;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'b0, busy}, {31'b0, m_left != 0});
      chk("done", {31'b0, done}, {31'b0, m_left == 1});
      chk("Y", Y, m_y);
    end
  end

  task automatic run_op(input string nm, input logic [4:0] f,
                        input logic [31:0] t, input logic [4:0] s,
                        input logic [31:0] ey, input int el);
    int k;
    k = 0;
    @(posedge clk); #1;
    start = 1; FS = f; T = t; shamt = s;
    @(posedge clk); #1;
    start = 0; FS = 5'h1F; T = ~t; shamt = ~s;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 100);
    chk({nm, " lat"}, k, el);
    chk({nm, " Y"}, Y, ey);
  endtask

  initial begin
    int k;
    // 1: reset held with start asserted
    reset = 0; start = 1; FS = FS_SLL; T = 32'h1; shamt = 0;
    @(posedge clk); #1 chk_en = 1;
    @(posedge clk); #1;
    chk("rst Y", Y, 32'h0);
    chk("rst busy", {31'b0, busy}, 32'h0);
    chk("rst done", {31'b0, done}, 32'h0);
    start = 0; reset = 1;
    @(posedge clk); #1;
    chk("rel busy", {31'b0, busy}, 32'h0);

    // 2..4 directed
`ifdef SHIFT_BY4_EN
    run_op("sll4", FS_SLL, 32'h0000_0001, 5'd4, 32'h0000_0010, 2);
    run_op("sra31", FS_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 11);
`else
    run_op("sll4", FS_SLL, 32'h0000_0001, 5'd4, 32'h0000_0010, 5);
    run_op("sra31", FS_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 32);
`endif
    run_op("srl0", FS_SRL, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1);
    run_op("inv0", 5'h1A, 32'hDEAD_BEEF, 5'd0, 32'h0, 1);
    run_op("inv5", 5'h1A, 32'h1234_5678, 5'd5, 32'h0, 1);
    run_op("sll7", FS_SLL, 32'h1234_5678, 5'd7, 32'h1A2B_3C00,
           ref_lat(FS_SLL, 5'd7));
    run_op("sll31", FS_SLL, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000,
           ref_lat(FS_SLL, 5'd31));
    run_op("srl31", FS_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001,
           ref_lat(FS_SRL, 5'd31));
    run_op("sra3", FS_SRA, 32'h7FFF_FFFF, 5'd3, 32'h0FFF_FFFF,
           ref_lat(FS_SRA, 5'd3));
    run_op("sra4n", FS_SRA, 32'hF000_0000, 5'd4, 32'hFF00_0000,
           ref_lat(FS_SRA, 5'd4));

    // 5: start during op is ignored
    @(posedge clk); #1;
    start = 1; FS = FS_SRL; T = 32'hF000_0000; shamt = 5'd8;
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      start = (i == 3);
      if (i == 3) begin FS = FS_SLL; T = 32'hFFFF_FFFF; shamt = 5'd1; end
      @(negedge clk);
      if (done) k++;
    end
    chk("t5 dones", k, 1);
    chk("t5 Y", Y, 32'h00F0_0000);

    // 6: reset mid-op
    @(posedge clk); #1;
    start = 1; FS = FS_SLL; T = 32'h0000_0003; shamt = 5'd20;
    k = 0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      start = 0;
      reset = (i != 10);
      @(negedge clk);
      if (i >= 11 && done) k++;
      if (i == 11) begin
        chk("t6 busy", {31'b0, busy}, 32'h0);
        chk("t6 Y", Y, 32'h0);
      end
    end
    chk("t6 dones", k, 0);
    run_op("post", FS_SLL, 32'h0000_0003, 5'd2, 32'h0000_000C,
           ref_lat(FS_SLL, 5'd2));

    @(posedge clk); @(posedge clk);
    @(negedge clk); #1;
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
